// File: rtl/mem_load_pkg.sv
// Shared widths, sizes and pipeline stage-entry types for the load unit.
// Optional build macro used by this block: LOAD_BYPASS_EN.
package mem_load_pkg;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int REG_AW    = 4;
    localparam int NREG      = 1 << REG_AW;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    // S1 carries the resolved address; S2 carries the word read from memory.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [ADDR_W-1:0] eff;
    } s1_entry_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } s2_entry_t;
endpackage

// File: rtl/mem_load_pipeline_if.sv
// Request, memory-write and result bundle of the load unit.
interface mem_load_pipeline_if;
    import mem_load_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] rs1;
    logic [ADDR_W-1:0] off;
    logic [REG_AW-1:0] rd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] zout;
    logic [REG_AW-1:0] zrd;

    modport master (
        output in_valid, rs1, off, rd, mem_we, mem_waddr, mem_wdata, out_ready,
        input  in_ready, out_valid, zout, zrd
    );
    modport slave (
        input  in_valid, rs1, off, rd, mem_we, mem_waddr, mem_wdata, out_ready,
        output in_ready, out_valid, zout, zrd
    );
endinterface

// File: rtl/load_regbank.sv
// Load-destination register bank: async-reset storage, one combinational read,
// one write port; with LOAD_BYPASS_EN the read sees a same-edge write.
module load_regbank
    import mem_load_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);
    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef LOAD_BYPASS_EN
    assign rdata = (we && waddr == raddr) ? wdata : regs[raddr];
`else
    assign rdata = regs[raddr];
`endif
endmodule

// File: rtl/mem_load_pipeline.sv
// 3-stage load unit: S1 resolves base+off, S2 reads memory (write-first),
// S3 writes the register bank and presents the result. Macro: LOAD_BYPASS_EN.
module mem_load_pipeline
    import mem_load_pkg::*;
(
    input logic               clk,
    input logic               rst,
    mem_load_pipeline_if.slave bus
);
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    s1_entry_t         s1;
    s2_entry_t         s2;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [REG_AW-1:0] res_rd;

    logic              freeze;
    logic              hazard;
    logic              accept;
    logic              wb_en;
    logic [DATA_W-1:0] base_word;
    logic [ADDR_W-1:0] eff_next;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_base_hi;

    load_regbank u_regbank (
        .clk   (clk),
        .rst   (rst),
        .raddr (bus.rs1),
        .rdata (base_word),
        .we    (wb_en),
        .waddr (s2.rd),
        .wdata (s2.data)
    );

    assign freeze = res_valid && !bus.out_ready;

    // Without forwarding the S2 writer is still invisible to the base read.
`ifdef LOAD_BYPASS_EN
    assign hazard = bus.in_valid && s1.valid && (s1.rd == bus.rs1);
`else
    assign hazard = bus.in_valid && ((s1.valid && (s1.rd == bus.rs1)) ||
                                     (s2.valid && (s2.rd == bus.rs1)));
`endif

    assign bus.in_ready = !freeze && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;
    assign wb_en        = s2.valid && !freeze;
    assign eff_next     = base_word[ADDR_W-1:0] + bus.off;
    assign unused_base_hi = ^base_word[DATA_W-1:ADDR_W];

    assign mem_rdata = (bus.mem_we && bus.mem_waddr == s1.eff) ? bus.mem_wdata
                                                               : mem[s1.eff];

    // Store-side write port: never stalled, not reset.
    always_ff @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
        end else if (!freeze) begin
            s1.valid <= accept;
            if (accept) begin
                s1.rd  <= bus.rd;
                s1.eff <= eff_next;
            end
            s2.valid  <= s1.valid;
            s2.rd     <= s1.rd;
            s2.data   <= mem_rdata;
            res_valid <= s2.valid;
            if (s2.valid) begin
                res_data <= s2.data;
                res_rd   <= s2.rd;
            end
        end
    end

    assign bus.out_valid = res_valid;
    assign bus.zout      = res_data;
    assign bus.zrd       = res_rd;
endmodule

// File: tb/tb_mem_load_pipeline.sv
// Scoreboard bench for mem_load_pipeline: sequential reference model of loads,
// monitor process compares every presented result in order.
module tb_mem_load_pipeline;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_load_pipeline_if bus();

    mem_load_pipeline dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct { logic [3:0] rd; logic [15:0] data; } exp_t;
    exp_t        exp_q[$];
    logic [15:0] mem_m [256];
    logic [15:0] reg_m [16];
    int          errors = 0;
    int          checks = 0;
    bit          stream_done;

`ifdef LOAD_BYPASS_EN
    localparam int EXP_STALL = 1;
`else
    localparam int EXP_STALL = 2;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Monitor: looks half a cycle ahead of the edge that completes a handshake.
    always @(negedge clk) begin
        #2;
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got zout=%h zrd=%0d expected none", bus.zout, bus.zrd);
            end else begin
                chk("zout", 32'(bus.zout), 32'(exp_q[0].data));
                chk("zrd",  32'(bus.zrd),  32'(exp_q[0].rd));
                if (bus.out_ready) void'(exp_q.pop_front());
                else chk("in_ready_frozen", 32'(bus.in_ready), 32'd0);
            end
        end
    end

    // Reference: loads take effect in program order.
    function automatic void model_load(input logic [3:0] rs1, input logic [7:0] off, input logic [3:0] rd);
        logic [7:0] eff;
        exp_t       e;
        eff       = reg_m[rs1][7:0] + off;
        e.rd      = rd;
        e.data    = mem_m[eff];
        reg_m[rd] = e.data;
        exp_q.push_back(e);
    endfunction

    task automatic load(input logic [3:0] rs1, input logic [7:0] off, input logic [3:0] rd, output int stalls);
        bus.in_valid = 1'b1; bus.rs1 = rs1; bus.off = off; bus.rd = rd;
        #1;
        stalls = 0;
        while (!bus.in_ready && stalls < 60) begin
            @(negedge clk); #1; stalls++;
        end
        if (stalls >= 60) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", stalls);
        end else begin
            model_load(rs1, off, rd);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [15:0] d);
        bus.mem_we = 1'b1; bus.mem_waddr = a; bus.mem_wdata = d;
        mem_m[a] = d;
        @(negedge clk);
        bus.mem_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        int st;
        logic [7:0] o;
        bus.in_valid = 0; bus.rs1 = 0; bus.off = 0; bus.rd = 0;
        bus.mem_we = 0; bus.mem_waddr = 0; bus.mem_wdata = 0; bus.out_ready = 1;
        for (int i = 0; i < 16; i++) reg_m[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_zout", 32'(bus.zout), 0);
        chk("reset_zrd", 32'(bus.zrd), 0);
        rst = 1'b0;
        #1 chk("idle_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);

        for (int a = 0; a < 256; a++) mem_write(8'(a), 16'($urandom));
        mem_write(8'd125, 16'd8);
        mem_write(8'd126, 16'd24);
        mem_write(8'd44, 16'hBEEF);
        mem_write(8'd50, 16'd200);
        mem_write(8'd8, 16'h0077);
        mem_write(8'd127, 16'h5555);

        // First load and its latency.
        load(4'd3, 8'd125, 4'd10, st);
        chk("first_stalls", st, 0);
        #1 chk("lat_e0", 32'(bus.out_valid), 0);
        @(negedge clk); #1 chk("lat_e1", 32'(bus.out_valid), 0);
        @(negedge clk); #1 chk("lat_e2", 32'(bus.out_valid), 1);
        drain();
        load(4'd10, 8'd0, 4'd11, st);   // regbank[10]=8 -> mem[8]
        drain();

        // Address wrap: 200 + 100 -> 44.
        load(4'd3, 8'd50, 4'd2, st);
        drain();
        load(4'd2, 8'd100, 4'd12, st);
        drain();

        // Dependent pair.
        load(4'd3, 8'd126, 4'd5, st);
        load(4'd5, 8'd20, 4'd6, st);
        chk("dep_stalls", st, EXP_STALL);
        drain();

        // Backpressure with 4 streamed loads.
        bus.out_ready = 1'b0;
        fork
            begin
                load(4'd3, 8'd125, 4'd7, st);
                load(4'd3, 8'd126, 4'd8, st);
                load(4'd3, 8'd44,  4'd9, st);
                load(4'd3, 8'd50,  4'd13, st);
            end
            begin
                repeat (6) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Random stream with random backpressure.
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    load(4'($urandom), 8'($urandom), 4'($urandom), st);
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Same-edge write to the address being read.
        o = 8'd127 - reg_m[4][7:0];
        mem_m[127] = 16'h1234;
        load(4'd4, o, 4'd14, st);
        mem_write(8'd127, 16'h1234);
        drain();

        // Async reset with two loads in flight.
        load(4'd3, 8'd125, 4'd10, st);
        load(4'd3, 8'd126, 4'd15, st);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 0);
        chk("arst_zout", 32'(bus.zout), 0);
        chk("arst_zrd", 32'(bus.zrd), 0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) reg_m[i] = '0;
        @(negedge clk);
        rst = 1'b0;
        load(4'd10, 8'd0, 4'd1, st);    // cleared regbank[10] -> mem[0]
        chk("post_reset_stalls", st, 0);
        drain();
        repeat (4) begin
            @(negedge clk); #1 chk("no_stale", 32'(bus.out_valid), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end
endmodule
